// File: rtl/eu_pkg.sv
// Shared types and opcode-class helpers for the eu_pipe execution unit.
package eu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_MUL   = 4'h8,
    OP_LOAD  = 4'hE,
    OP_STORE = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes 0..ALU_OP_LAST are the single-cycle ALU class.
  localparam logic [3:0] ALU_OP_LAST = 4'h7;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= ALU_OP_LAST;
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/eu_alu.sv
// Combinational single-cycle ALU: arithmetic, logic and 1-bit shifts with carry/borrow.
module eu_alu
  import eu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the borrow, i.e. a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eu_pipe.sv
// Single-issue execution unit with a one-entry output slot and optional iterative
// shift-add multiplier (enabled by defining EU_MUL_EN; otherwise opcode 8 is a NOP).
module eu_pipe
  import eu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [MEM_AW-1:0] mem_adr,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_we,
  output logic              out_mem_we,
  output logic [REG_AW-1:0] out_dest,
  output logic [MEM_AW-1:0] out_adr,
  output logic [DATA_W-1:0] out_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy
);

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                slot_free;
  logic                accept;
  logic                mul_load;
  logic [2*DATA_W-1:0] mul_prod;
  logic [REG_AW-1:0]   mul_dest;

  eu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (opcode),
    .a      (operand_a),
    .b      (operand_b),
    .result (alu_res),
    .carry  (alu_c)
  );

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

`ifdef EU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t              state_q, state_d;
  logic [2*DATA_W-1:0] mcand_p1;
  logic [2*DATA_W-1:0] acc_p1;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W-1:0]   mplier_p1;
  logic [CNT_W-1:0]    cnt_p1;
  logic [REG_AW-1:0]   mul_dest_p1;

  assign acc_step = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && is_mul_op(opcode)) state_d = ST_MUL;
      ST_MUL: begin
        if (cnt_p1 == CNT_W'(DATA_W - 1)) begin
          if (slot_free) begin
            mul_load = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (slot_free) begin
          mul_load = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiplier datapath: one partial product per cycle; acc holds the product in DONE.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && accept && is_mul_op(opcode)) begin
      mcand_p1    <= {{DATA_W{1'b0}}, operand_a};
      mplier_p1   <= operand_b;
      acc_p1      <= '0;
      cnt_p1      <= '0;
      mul_dest_p1 <= dest_reg;
    end else if (state_q == ST_MUL) begin
      acc_p1    <= acc_step;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      cnt_p1    <= cnt_p1 + 1'b1;
    end
  end

  assign mul_prod = (state_q == ST_DONE) ? acc_p1 : acc_step;
  assign mul_dest = mul_dest_p1;
  assign in_ready = (state_q == ST_IDLE) && slot_free;
  assign busy     = (state_q != ST_IDLE);
`else
  assign mul_load = 1'b0;
  assign mul_prod = '0;
  assign mul_dest = '0;
  assign in_ready = slot_free;
  assign busy     = 1'b0;
`endif

  // Output slot: a new result wins over draining; flags move only on ALU/MUL results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_reg_we <= 1'b0;
      out_mem_we <= 1'b0;
      out_dest   <= '0;
      out_adr    <= '0;
      out_data   <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
    end else if (mul_load) begin
      out_valid  <= 1'b1;
      out_reg_we <= 1'b1;
      out_mem_we <= 1'b0;
      out_dest   <= mul_dest;
      out_data   <= mul_prod[DATA_W-1:0];
      flag_z     <= (mul_prod[DATA_W-1:0] == '0);
      flag_c     <= |mul_prod[2*DATA_W-1:DATA_W];
    end else if (accept && is_alu_op(opcode)) begin
      out_valid  <= 1'b1;
      out_reg_we <= 1'b1;
      out_mem_we <= 1'b0;
      out_dest   <= dest_reg;
      out_data   <= alu_res;
      flag_z     <= (alu_res == '0);
      flag_c     <= alu_c;
    end else if (accept && opcode == OP_LOAD) begin
      out_valid  <= 1'b1;
      out_reg_we <= 1'b1;
      out_mem_we <= 1'b0;
      out_dest   <= dest_reg;
      out_data   <= mem_rdata;
    end else if (accept && opcode == OP_STORE) begin
      out_valid  <= 1'b1;
      out_reg_we <= 1'b0;
      out_mem_we <= 1'b1;
      out_adr    <= mem_adr;
      out_data   <= operand_a;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      out_reg_we <= 1'b0;
      out_mem_we <= 1'b0;
    end
  end

endmodule
